// File: rtl/adaptive_mu_ctrl_if.sv
// Bus between the LMS filter error output and the step-size scheduler.
// The filter side (master) supplies error samples; the scheduler side (slave)
// returns the step shift, window statistics, state and filter reset.
interface adaptive_mu_ctrl_if #(
    parameter int EW = 33
);
    logic signed [EW-1:0] e_in;
    logic                 e_valid;
    logic [7:0]           mu_out;
    logic [EW-1:0]        msa_out;
    logic                 msa_valid;
    logic [1:0]           state_out;
    logic                 converged;
    logic                 div_flag;
    logic                 filt_rst_n;

    modport master (
        output e_in, e_valid,
        input  mu_out, msa_out, msa_valid, state_out, converged, div_flag, filt_rst_n
    );

    modport slave (
        input  e_in, e_valid,
        output mu_out, msa_out, msa_valid, state_out, converged, div_flag, filt_rst_n
    );
endinterface

// File: rtl/adaptive_mu_ctrl.sv
// Step-size scheduler and convergence monitor for the 16-tap LMS filter.
// Averages |e| over fixed windows of accepted samples and steps the filter
// through ACQUIRE (coarse mu) / TRACK (fine mu) / RECOVER (filter held in reset).
module adaptive_mu_ctrl #(
    parameter int EW        = 33,
    parameter int WIN_LOG2  = 8,
    parameter int MU_COARSE = 4,
    parameter int MU_FINE   = 8,
    parameter int THR_CONV  = 64,
    parameter int THR_DIV   = 65536,
    parameter int RST_CYC   = 16
) (
    input  logic              clk,
    input  logic              reset,
    adaptive_mu_ctrl_if.slave bus
);

    localparam int AW = EW + WIN_LOG2;                       // accumulator width, never overflows
    localparam int TW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1; // RECOVER timer width

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic [EW-1:0]       THR_CONV_V = EW'(THR_CONV);
    localparam logic [EW-1:0]       THR_LOST_V = EW'(4 * THR_CONV);
    localparam logic [EW-1:0]       THR_DIV_V  = EW'(THR_DIV);
    localparam logic [WIN_LOG2-1:0] CNT_LAST   = {WIN_LOG2{1'b1}};
    localparam logic [TW-1:0]       TMR_LAST   = TW'(RST_CYC - 1);
    localparam logic [7:0]          MU_C_V     = 8'(MU_COARSE);
    localparam logic [7:0]          MU_F_V     = 8'(MU_FINE);

    // Two's-complement magnitude; the most-negative code maps to 2^(EW-1),
    // which still fits in EW unsigned bits.
    function automatic logic [EW-1:0] abs_f(input logic [EW-1:0] v);
        logic [EW-1:0] r;
        if (v[EW-1]) begin
            r = (~v) + {{(EW-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // State and datapath registers
    state_t              state_r;
    logic                good_r;      // one good window already seen in ACQUIRE
    logic [AW-1:0]       acc_r;
    logic [WIN_LOG2-1:0] cnt_r;
    logic [TW-1:0]       tmr_r;

    // Registered outputs
    logic [7:0]          mu_r;
    logic [EW-1:0]       msa_r;
    logic                msa_valid_r;
    logic                conv_r;
    logic                div_r;
    logic                frst_r;

    // Combinational helpers
    state_t              state_nx_s;
    logic                good_nx_s;
    logic [EW-1:0]       abs_s;
    logic [AW-1:0]       sum_s;
    logic [EW-1:0]       mean_s;
    logic                accept_s;
    logic                close_s;
    logic                div_s;
    logic                good_win_s;
    logic                lost_s;
    logic                tmr_done_s;
    logic [7:0]          mu_nx_s;
    logic                conv_nx_s;
    logic                frst_nx_s;

    assign abs_s      = abs_f(bus.e_in);
    assign sum_s      = acc_r + AW'(abs_s);
    assign mean_s     = EW'(sum_s >> WIN_LOG2);
    assign accept_s   = bus.e_valid && (state_r != ST_RECOVER);
    assign close_s    = accept_s && (cnt_r == CNT_LAST);
    assign div_s      = (mean_s > THR_DIV_V);
    assign good_win_s = (mean_s < THR_CONV_V);
    assign lost_s     = (mean_s >= THR_LOST_V);
    assign tmr_done_s = (tmr_r == TMR_LAST);

    // FSM state register and consecutive-good tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_ACQUIRE;
            good_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            good_r  <= good_nx_s;
        end
    end

    // FSM next-state: decisions only at window close (or RECOVER timeout)
    always_comb begin
        state_nx_s = state_r;
        good_nx_s  = good_r;
        case (state_r)
            ST_ACQUIRE: begin
                if (close_s) begin
                    if (div_s) begin
                        state_nx_s = ST_RECOVER;
                        good_nx_s  = 1'b0;
                    end else if (good_win_s) begin
                        if (good_r) begin
                            state_nx_s = ST_TRACK;
                            good_nx_s  = 1'b0;
                        end else begin
                            state_nx_s = ST_ACQUIRE;
                            good_nx_s  = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_ACQUIRE;
                        good_nx_s  = 1'b0;
                    end
                end else begin
                    state_nx_s = ST_ACQUIRE;
                    good_nx_s  = good_r;
                end
            end
            ST_TRACK: begin
                if (close_s) begin
                    if (div_s) begin
                        state_nx_s = ST_RECOVER;
                        good_nx_s  = 1'b0;
                    end else if (lost_s) begin
                        state_nx_s = ST_ACQUIRE;
                        good_nx_s  = 1'b0;
                    end else begin
                        state_nx_s = ST_TRACK;
                        good_nx_s  = 1'b0;
                    end
                end else begin
                    state_nx_s = ST_TRACK;
                    good_nx_s  = good_r;
                end
            end
            ST_RECOVER: begin
                good_nx_s = 1'b0;
                if (tmr_done_s) begin
                    state_nx_s = ST_ACQUIRE;
                end else begin
                    state_nx_s = ST_RECOVER;
                end
            end
            default: begin
                state_nx_s = ST_ACQUIRE;
                good_nx_s  = 1'b0;
            end
        endcase
    end

    // FSM outputs derived from the next state so they register alongside it
    always_comb begin
        mu_nx_s   = MU_C_V;
        conv_nx_s = 1'b0;
        frst_nx_s = 1'b1;
        case (state_nx_s)
            ST_ACQUIRE: begin
                mu_nx_s   = MU_C_V;
                conv_nx_s = 1'b0;
                frst_nx_s = 1'b1;
            end
            ST_TRACK: begin
                mu_nx_s   = MU_F_V;
                conv_nx_s = 1'b1;
                frst_nx_s = 1'b1;
            end
            ST_RECOVER: begin
                mu_nx_s   = MU_C_V;
                conv_nx_s = 1'b0;
                frst_nx_s = 1'b0;
            end
            default: begin
                mu_nx_s   = MU_C_V;
                conv_nx_s = 1'b0;
                frst_nx_s = 1'b1;
            end
        endcase
    end

    // Window accumulator/counter and RECOVER timer; RECOVER holds the window at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {AW{1'b0}};
            cnt_r <= {WIN_LOG2{1'b0}};
            tmr_r <= {TW{1'b0}};
        end else if (state_r == ST_RECOVER) begin
            acc_r <= {AW{1'b0}};
            cnt_r <= {WIN_LOG2{1'b0}};
            if (tmr_done_s) begin
                tmr_r <= {TW{1'b0}};
            end else begin
                tmr_r <= tmr_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            tmr_r <= {TW{1'b0}};
            if (close_s) begin
                acc_r <= {AW{1'b0}};
                cnt_r <= {WIN_LOG2{1'b0}};
            end else if (accept_s) begin
                acc_r <= sum_s;
                cnt_r <= cnt_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end
    end

    // Output registers: window mean, pulse, mode outputs and sticky divergence flag
    always_ff @(posedge clk) begin
        if (reset) begin
            mu_r        <= MU_C_V;
            msa_r       <= {EW{1'b0}};
            msa_valid_r <= 1'b0;
            conv_r      <= 1'b0;
            div_r       <= 1'b0;
            frst_r      <= 1'b1;
        end else begin
            mu_r        <= mu_nx_s;
            conv_r      <= conv_nx_s;
            frst_r      <= frst_nx_s;
            msa_valid_r <= close_s;
            if (close_s) begin
                msa_r <= mean_s;
            end else begin
                msa_r <= msa_r;
            end
            div_r <= div_r | ((state_nx_s == ST_RECOVER) && (state_r != ST_RECOVER));
        end
    end

    assign bus.mu_out     = mu_r;
    assign bus.msa_out    = msa_r;
    assign bus.msa_valid  = msa_valid_r;
    assign bus.state_out  = state_r;
    assign bus.converged  = conv_r;
    assign bus.div_flag   = div_r;
    assign bus.filt_rst_n = frst_r;

endmodule

// File: doc/adaptive_mu_ctrl.md
# adaptive_mu_ctrl

Step-size scheduler and convergence monitor sitting directly downstream of the 16-tap LMS filter. It consumes the filter's registered error `e_out` and computes the mean absolute error over fixed windows. From that it drives the filter's `mu_in` (shift amount: larger value gives a smaller step) through an acquire/track/recover state machine. On divergence it pulses the filter's active-low reset to restart adaptation from zero taps.

## Interface
Parameters:
- `EW`, 33, error input width (matches filter `e_out`)
- `WIN_LOG2`, 8, window length = 2^WIN_LOG2 valid samples
- `MU_COARSE`, 4, shift used while acquiring
- `MU_FINE`, 8, shift used while tracking
- `THR_CONV`, 64, window mean |e| below which the window counts as converged
- `THR_DIV`, 65536, window mean |e| above which the filter is declared diverged
- `RST_CYC`, 16, length of filter reset pulse in cycles

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `e_in`  in  EW  signed error sample from filter `e_out`
- `e_valid`  in  1  `e_in` valid this cycle
- `mu_out`  out  8  step shift to filter `mu_in`
- `msa_out`  out  EW  unsigned window mean |e|
- `msa_valid`  out  1  one-cycle pulse, `msa_out` updated
- `state_out`  out  2  0=ACQUIRE, 1=TRACK, 2=RECOVER
- `converged`  out  1  high while in TRACK
- `div_flag`  out  1  sticky divergence indicator, cleared only by `reset`
- `filt_rst_n`  out  1  active-low reset to filter, low during RECOVER

## Operation
- |e|: two's-complement magnitude, EW-bit unsigned. The most-negative input maps to 2^(EW-1) exactly, with no overflow.
- Accumulator is unsigned, EW+WIN_LOG2 bits, and cannot overflow.
- Window counter is WIN_LOG2 bits and counts accepted samples. A sample is accepted when `e_valid`=1 and state != RECOVER.
- Window close: an accepted sample arrives with count = 2^WIN_LOG2-1.
  - mean = (acc + |e|) >> WIN_LOG2, truncated.
  - acc and count are cleared. The next accepted sample starts a fresh window.
- FSM decisions are taken only at window close, evaluated on the new mean.
- ACQUIRE (`mu_out`=MU_COARSE):
  - mean > THR_DIV → RECOVER.
  - else mean < THR_CONV on 2 consecutive windows → TRACK. The consecutive-good counter resets on any window with mean >= THR_CONV.
  - else stay.
- TRACK (`mu_out`=MU_FINE):
  - mean > THR_DIV → RECOVER.
  - else mean >= 4*THR_CONV → ACQUIRE (lost lock), good counter cleared.
  - else stay.
- RECOVER (`mu_out`=MU_COARSE):
  - `filt_rst_n`=0 for exactly RST_CYC cycles.
  - acc, count and good counter are held at 0. `e_valid` is ignored.
  - After RST_CYC cycles → ACQUIRE, `filt_rst_n`=1.
- `div_flag` is set on entry to RECOVER.
- Priority at a window close: divergence test first, then lost-lock or convergence.

## Timing
- Reset values: `mu_out`=MU_COARSE, `msa_out`=0, `msa_valid`=0, `state_out`=0, `converged`=0, `div_flag`=0, `filt_rst_n`=1. Accumulator, counters and RECOVER timer are 0. `reset` overrides all other inputs, including mid-window and mid-RECOVER.
- Latency: on the edge that accepts the closing sample, the following update together and are visible in the next cycle:
  - `msa_out`, `msa_valid`=1
  - the new state, `mu_out`, `converged`, `div_flag`
  - `filt_rst_n` (falls to 0 on RECOVER entry)
- `msa_valid` is high for exactly 1 cycle per window. There is no back-pressure, and back-to-back windows are allowed with gapless `e_valid`.
- RECOVER duration: `filt_rst_n` low for cycles 1..RST_CYC after the closing edge. State reads ACQUIRE and `filt_rst_n`=1 in cycle RST_CYC+1.
- The filter's `e_out` reflects a new `mu_in` only after the filter pipeline delay. The block does not compensate; the window boundary absorbs it.
- `e_valid` gaps stretch the window and do not break it.

## Test plan
Bench overrides: WIN_LOG2=4, THR_CONV=16, THR_DIV=4096, RST_CYC=16.

- **Reset:** hold `reset` 3 cycles, then release with no `e_valid` → all outputs at reset values, `mu_out`=4, no `msa_valid` over 100 cycles.
- **Convergence:** 32 gapless samples of e=-10 → `msa_valid` pulses after samples 16 and 32, each with `msa_out`=10. After the 32nd: state=TRACK, `mu_out`=8, `converged`=1.
- **Lost lock and gaps:** from TRACK, 16 samples of e=+100 with `e_valid` toggling every other cycle → a single `msa_valid` with `msa_out`=100. State=ACQUIRE, `mu_out`=4, good counter cleared, so one further window of e=5 stays in ACQUIRE.
- **Divergence:** 16 samples of e=-2^32 → `msa_out`=2^32. State=RECOVER, `div_flag`=1, `filt_rst_n`=0 for exactly 16 cycles. `e_valid` pulses during RECOVER are not counted. Then ACQUIRE, and the next window needs 16 fresh samples.
- **Truncation and non-consecutive windows:** windows of 15×e=0 plus 1×e=255 give `msa_out`=15 (<16, good). A following window of mean 16 → still ACQUIRE. A further good window alone → no TRACK.
- **Mid-operation reset:** assert `reset` during cycle 5 of RECOVER, and separately after sample 9 of a window → `filt_rst_n`=1, `div_flag`=0 and count=0 the next cycle. The following window closes only after 16 new samples.
